fpu_add_wb: RTL and testbench
=============================

# fpu_add_wb

Result writeback stage directly downstream of the half-precision FPU adder. Captures each valid adder result with its destination-register tag into a small FIFO, presents results to the register-file write port over a valid/ready handshake, and keeps sticky IEEE-style exception flags (NaN, infinity, overflow) for the CPU status register. Absorbs register-file write-port conflicts so the adder's issue logic only needs back-pressure via `o_ready`.

## Interface
- `DEPTH`, 4: FIFO entries; power of 2, minimum 2.
- `TAG_W`, 4: destination register tag width.

- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_res`  in  16  adder result (sign, exp[14:10], man[9:0]).
- `i_res_vld`  in  1  adder result valid.
- `i_overflow`  in  1  adder overflow/exception indication.
- `i_tag`  in  TAG_W  destination register tag issued alongside the operands.
- `o_ready`  out  1  FIFO can accept; equals !full.
- `o_wb_data`  out  16  head entry result; 0 when empty.
- `o_wb_tag`  out  TAG_W  head entry tag; 0 when empty.
- `o_wb_vld`  out  1  head entry valid (FIFO non-empty).
- `i_wb_rdy`  in  1  register file accepts head this cycle.
- `o_flags`  out  3  sticky {nan, inf, ovf}.
- `i_flags_clr`  in  1  clear sticky flags.
- `o_count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Push: `i_res_vld && o_ready` at a rising edge writes {i_res, i_tag} at write pointer; write pointer increments.
- `i_res_vld` while `o_ready`=0: result dropped, no state change; upstream guarantees not to issue (verified by assertion).
- Pop: `o_wb_vld && i_wb_rdy` at a rising edge advances read pointer.
- Simultaneous push and pop: both occur, count unchanged. When full, push is refused even if pop occurs that cycle (`o_ready` is combinational from registered count only; no pass-through).
- Pointers: log2(DEPTH)+1 bits; wrap naturally; empty when equal, full when MSBs differ and remaining bits equal.
- Classification on push, from `i_res`: nan = exp==5'h1F && man!=0; inf = exp==5'h1F && man==0; ovf = i_overflow && !nan && !inf.
- Flags: each bit ORs in its classification on every push; `i_flags_clr` zeroes all bits; clear and set in same cycle: set wins for bits being set, others clear.
- Data stored verbatim; no re-rounding or canonicalisation (adder already emits quiet NaN 16'h7E00).

## Timing
- Reset (asynchronous, any time): pointers, count, storage, `o_flags` all 0; `o_wb_vld`=0, `o_wb_data`=0, `o_wb_tag`=0, `o_ready`=1. Reset mid-operation discards all queued entries.
- Latency: result pushed at edge N is visible on `o_wb_*` immediately after edge N if FIFO was empty; otherwise after all older entries pop.
- Throughput: one push and one pop per cycle sustained.
- `o_wb_data`/`o_wb_tag` stable while `o_wb_vld`=1 and `i_wb_rdy`=0.
- `o_flags` updates one edge after the push that sets it; `o_count` registered.

## Structure
- Shared package `fpu_pkg`: HP_EXP_MAX = 5'h1F, HP_QNAN = 16'h7E00, field bit positions, flag bit indices (FLAG_NAN=2, FLAG_INF=1, FLAG_OVF=0).
- One sub-module `fpu_res_fifo` (generic synchronous FIFO, width 16+TAG_W, parameter DEPTH, full/empty/count); top holds classification and sticky flags.

## Test plan
- Reset then push 16'h3C00 tag 3 with `i_wb_rdy`=1 -> next cycle `o_wb_vld`=1, data 16'h3C00, tag 3; following cycle empty, `o_flags`=0.
- `i_wb_rdy`=0, push 4 results 0x3C00..0x3C03 tags 0..3 -> `o_ready`=0, `o_count`=4; 5th push dropped; release -> pops in order 0x3C00..0x3C03.
- Full FIFO, push and pop same cycle -> pop occurs, push refused, `o_count`=3; next cycle push accepted, `o_count`=4.
- Push 16'h7E00 with `i_overflow`=1, then 16'hFC00, then 16'h7BFF with `i_overflow`=1 -> `o_flags` 3'b100, 3'b110, 3'b111.
- `i_flags_clr`=1 same cycle as push of 16'h7C00 -> `o_flags`=3'b010.
- Assert `i_rst_n`=0 mid-cycle with 2 entries queued -> outputs 0 and `o_ready`=1 immediately, before next edge.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared half-precision constants and the result classification helper used by the
// writeback stage.
package fpu_pkg;

    localparam logic [4:0]  HP_EXP_MAX = 5'h1F;
    localparam logic [15:0] HP_QNAN    = 16'h7E00;

    localparam int unsigned HP_EXP_MSB = 14;
    localparam int unsigned HP_EXP_LSB = 10;
    localparam int unsigned HP_MAN_MSB = 9;
    localparam int unsigned HP_MAN_LSB = 0;

    localparam int unsigned FLAG_NAN = 2;
    localparam int unsigned FLAG_INF = 1;
    localparam int unsigned FLAG_OVF = 0;

    // An overflow is only reported when the result is a finite number.
    function automatic logic [2:0] classify(input logic [15:0] res, input logic ovf);
        logic [4:0] exp_f;
        logic [9:0] man_f;
        logic [2:0] flags;
        exp_f = res[HP_EXP_MSB:HP_EXP_LSB];
        man_f = res[HP_MAN_MSB:HP_MAN_LSB];
        flags = '0;
        flags[FLAG_NAN] = (exp_f == HP_EXP_MAX) && (man_f != '0);
        flags[FLAG_INF] = (exp_f == HP_EXP_MAX) && (man_f == '0);
        flags[FLAG_OVF] = ovf && !flags[FLAG_NAN] && !flags[FLAG_INF];
        return flags;
    endfunction

endpackage

// File: rtl/fpu_add_wb_if.sv
// Adder-result and register-file writeback signals of the FPU add writeback stage.
// The slave modport is the writeback stage's own view.
interface fpu_add_wb_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [15:0]      i_res;
    logic             i_res_vld;
    logic             i_overflow;
    logic [TAG_W-1:0] i_tag;
    logic             o_ready;
    logic [15:0]      o_wb_data;
    logic [TAG_W-1:0] o_wb_tag;
    logic             o_wb_vld;
    logic             i_wb_rdy;
    logic [2:0]       o_flags;
    logic             i_flags_clr;
    logic [CW-1:0]    o_count;

    modport slave (
        input  i_res, i_res_vld, i_overflow, i_tag, i_wb_rdy, i_flags_clr,
        output o_ready, o_wb_data, o_wb_tag, o_wb_vld, o_flags, o_count
    );

    modport master (
        output i_res, i_res_vld, i_overflow, i_tag, i_wb_rdy, i_flags_clr,
        input  o_ready, o_wb_data, o_wb_tag, o_wb_vld, o_flags, o_count
    );

endinterface

// File: rtl/fpu_res_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers; read data reads as zero when empty.
module fpu_res_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 20,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    assign o_empty = (wptr_q == rptr_q);
    assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;
    assign o_rdata = o_empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign o_count = count_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wptr_q[AW-1:0]] <= i_wdata;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fpu_add_wb.sv
// Writeback stage behind the half-precision adder: queues {result, tag} for the register
// file and keeps sticky NaN / infinity / overflow flags for the status register.
module fpu_add_wb
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input logic          i_clk,
    input logic          i_rst_n,
    fpu_add_wb_if.slave  bus
);

    localparam int unsigned W  = 16 + TAG_W;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          push, pop, full, empty;
    logic [W-1:0]  rdata;
    logic [CW-1:0] count;
    logic [2:0]    cls, flags_d, flags_q;

    // Ready depends only on registered state; a pop never frees a slot for the same edge.
    assign push = bus.i_res_vld && !full;
    assign pop  = bus.i_wb_rdy && !empty;

    fpu_res_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_wdata ({bus.i_res, bus.i_tag}),
        .o_rdata (rdata),
        .o_full  (full),
        .o_empty (empty),
        .o_count (count)
    );

    assign bus.o_ready                   = !full;
    assign bus.o_wb_vld                  = !empty;
    assign {bus.o_wb_data, bus.o_wb_tag} = rdata;
    assign bus.o_count                   = count;
    assign bus.o_flags                   = flags_q;

    // Clear and set in the same cycle: bits being set survive the clear.
    always_comb begin
        cls     = classify(bus.i_res, bus.i_overflow);
        flags_d = bus.i_flags_clr ? '0 : flags_q;
        if (push) begin
            flags_d = flags_d | cls;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    // A result offered while full must leave the queue untouched.
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (bus.i_res_vld && !bus.o_ready && !pop) |=> (bus.o_count == $past(bus.o_count)));

endmodule

// File: tb/tb_fpu_add_wb.sv
// Self-checking bench for fpu_add_wb: directed vectors, hand-written corner sequences
// and randomized traffic against a queue-based reference model.
module tb_fpu_add_wb;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [19:0] mq[$];
    logic [2:0]  mflags;

    fpu_add_wb_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    fpu_add_wb #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic        vld;
        logic        ovf;
        logic [3:0]  tag;
        logic        rdy;
        logic        clr;
        logic        ex_vld;
        logic [15:0] ex_data;
        logic [3:0]  ex_tag;
        logic [2:0]  ex_flags;
        logic [2:0]  ex_count;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_flags(input logic [15:0] r, input logic ovf);
        int  e;
        int  m;
        bit  nan;
        bit  inf;
        e   = int'(r) / 1024 % 32;
        m   = int'(r) % 1024;
        nan = (e == 31) && (m != 0);
        inf = (e == 31) && (m == 0);
        return {nan, inf, ovf && !nan && !inf};
    endfunction

    task automatic compare_model(input string tagname);
        logic [19:0] h;
        h = (mq.size() > 0) ? mq[0] : 20'h0;
        chk({tagname, "_vld"},   32'(bus.o_wb_vld),  32'(mq.size() > 0));
        chk({tagname, "_data"},  32'(bus.o_wb_data), 32'(h[19:4]));
        chk({tagname, "_tag"},   32'(bus.o_wb_tag),  32'(h[3:0]));
        chk({tagname, "_count"}, 32'(bus.o_count),   32'(mq.size()));
        chk({tagname, "_ready"}, 32'(bus.o_ready),   32'(mq.size() < DEPTH));
        chk({tagname, "_flags"}, 32'(bus.o_flags),   32'(mflags));
    endtask

    // Drive one cycle, advance the model past the edge, then compare.
    task automatic cycle(input logic [15:0] res, input logic vld, input logic ovf,
                         input logic [3:0] tag, input logic rdy, input logic clr,
                         input string tagname);
        bit acc;
        bit popped;
        bus.i_res       = res;
        bus.i_res_vld   = vld;
        bus.i_overflow  = ovf;
        bus.i_tag       = tag;
        bus.i_wb_rdy    = rdy;
        bus.i_flags_clr = clr;
        acc    = vld && (mq.size() < DEPTH);
        popped = rdy && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (popped) void'(mq.pop_front());
        if (acc) mq.push_back({res, tag});
        if (clr) mflags = 3'b000;
        if (acc) mflags = mflags | ref_flags(res, ovf);
        compare_model(tagname);
    endtask

    initial begin
        logic [15:0] r;
        logic [1:0]  kind;
        checks = 0;
        errors = 0;
        mflags = 3'b000;
        rst_n  = 1'b0;
        bus.i_res = '0;
        bus.i_res_vld = 1'b0;
        bus.i_overflow = 1'b0;
        bus.i_tag = '0;
        bus.i_wb_rdy = 1'b0;
        bus.i_flags_clr = 1'b0;

        tbl[0] = '{fpu_pkg::HP_QNAN, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0,
                   1'b1, 16'h7E00, 4'd1, 3'b100, 3'd1};
        tbl[1] = '{16'hFC00, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0,
                   1'b1, 16'hFC00, 4'd2, 3'b110, 3'd1};
        tbl[2] = '{16'h7BFF, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0,
                   1'b1, 16'h7BFF, 4'd3, 3'b111, 3'd1};
        tbl[3] = '{16'h7C00, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1,
                   1'b1, 16'h7C00, 4'd4, 3'b010, 3'd1};
        tbl[4] = '{16'h0000, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1,
                   1'b0, 16'h0000, 4'd0, 3'b000, 3'd0};
        tbl[5] = '{16'h7C01, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0,
                   1'b1, 16'h7C01, 4'd5, 3'b100, 3'd1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld",   32'(bus.o_wb_vld),  32'h0);
        chk("rst_data",  32'(bus.o_wb_data), 32'h0);
        chk("rst_tag",   32'(bus.o_wb_tag),  32'h0);
        chk("rst_ready", 32'(bus.o_ready),   32'h1);
        chk("rst_count", 32'(bus.o_count),   32'h0);
        chk("rst_flags", 32'(bus.o_flags),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single push, immediate visibility, then drained.
        cycle(16'h3C00, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, "t1_push");
        chk("t1_vld",  32'(bus.o_wb_vld),  32'h1);
        chk("t1_data", 32'(bus.o_wb_data), 32'h3C00);
        chk("t1_tag",  32'(bus.o_wb_tag),  32'h3);
        cycle(16'h0000, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "t1_idle");
        chk("t1_empty", 32'(bus.o_wb_vld), 32'h0);
        chk("t1_flags", 32'(bus.o_flags),  32'h0);

        // Fill under back-pressure, then a dropped fifth push.
        for (int i = 0; i < 4; i++) begin
            cycle(16'h3C00 + 16'(i), 1'b1, 1'b0, 4'(i), 1'b0, 1'b0, "t2_fill");
        end
        chk("t2_ready", 32'(bus.o_ready), 32'h0);
        chk("t2_count", 32'(bus.o_count), 32'h4);
        cycle(16'h3C04, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, "t2_drop");
        chk("t2_drop_count", 32'(bus.o_count),   32'h4);
        chk("t2_drop_head",  32'(bus.o_wb_data), 32'h3C00);

        // Full: push and pop together, push refused; next cycle push accepted.
        cycle(16'h3C05, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, "t3_pp");
        chk("t3_pp_count", 32'(bus.o_count),   32'h3);
        chk("t3_pp_head",  32'(bus.o_wb_data), 32'h3C01);
        cycle(16'h3C06, 1'b1, 1'b0, 4'd6, 1'b0, 1'b0, "t3_push");
        chk("t3_push_count", 32'(bus.o_count), 32'h4);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp_head;
            exp_head = (i == 0) ? 16'h3C02 : (i == 1) ? 16'h3C03 : (i == 2) ? 16'h3C06 : 16'h0;
            cycle(16'h0000, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "t3_drain");
            chk($sformatf("t3_order%0d", i), 32'(bus.o_wb_data), 32'(exp_head));
        end

        // Flag classification vectors.
        foreach (tbl[i]) begin
            cycle(tbl[i].res, tbl[i].vld, tbl[i].ovf, tbl[i].tag, tbl[i].rdy, tbl[i].clr,
                  $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_x_vld", i),   32'(bus.o_wb_vld),  32'(tbl[i].ex_vld));
            chk($sformatf("vec%0d_x_data", i),  32'(bus.o_wb_data), 32'(tbl[i].ex_data));
            chk($sformatf("vec%0d_x_tag", i),   32'(bus.o_wb_tag),  32'(tbl[i].ex_tag));
            chk($sformatf("vec%0d_x_flags", i), 32'(bus.o_flags),   32'(tbl[i].ex_flags));
            chk($sformatf("vec%0d_x_count", i), 32'(bus.o_count),   32'(tbl[i].ex_count));
        end

        // Asynchronous reset between edges with two entries queued.
        cycle(16'h7C00, 1'b1, 1'b0, 4'd6, 1'b0, 1'b0, "t6_q2");
        chk("t6_pre_count", 32'(bus.o_count), 32'h2);
        bus.i_res_vld = 1'b0;
        bus.i_wb_rdy  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_vld",   32'(bus.o_wb_vld),  32'h0);
        chk("t6_data",  32'(bus.o_wb_data), 32'h0);
        chk("t6_tag",   32'(bus.o_wb_tag),  32'h0);
        chk("t6_ready", 32'(bus.o_ready),   32'h1);
        chk("t6_count", 32'(bus.o_count),   32'h0);
        chk("t6_flags", 32'(bus.o_flags),   32'h0);
        mq.delete();
        mflags = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic, biased towards NaN/Inf encodings and a full queue.
        for (int n = 0; n < 2000; n++) begin
            kind = 2'($urandom_range(0, 3));
            r    = 16'($urandom);
            if (kind == 2'd0) r[14:10] = 5'h1F;
            if (kind == 2'd1) r = {r[15], 5'h1F, 10'h0};
            cycle(r, $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom),
                  (n % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0),
                  $urandom_range(0, 15) == 0, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
